// File: rtl/inv_bvcmp_bvmul_search_if.sv
// Request/result handshake bundle for the (x * s) CMP t inverse solver.
interface inv_bvcmp_bvmul_search_if #(
  parameter int unsigned W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_s;
  logic [W-1:0] in_t;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic         out_found;
  logic [W-1:0] out_x;

  modport slave (
    input  in_valid, in_s, in_t, in_mode, out_ready,
    output in_ready, out_valid, out_found, out_x
  );

  modport master (
    output in_valid, in_s, in_t, in_mode, out_ready,
    input  in_ready, out_valid, out_found, out_x
  );
endinterface

// File: rtl/inv_bvcmp_bvmul_search.sv
// Sequential search for the smallest x with (x * s mod 2^W) CMP t, one candidate per cycle.
// Optional macro INV_COND_EN: early-out on the closed-form invertibility condition.
module inv_bvcmp_bvmul_search #(
  parameter int unsigned W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  inv_bvcmp_bvmul_search_if.slave      bus
);

  localparam int unsigned CW = W + 1;
  localparam logic [CW-1:0] LAST = {1'b0, {W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        r_state,     w_state_nxt;
  logic [CW-1:0] r_cnt,       w_cnt_nxt;
  logic [W-1:0]  r_s,         w_s_nxt;
  logic [W-1:0]  r_t,         w_t_nxt;
  logic [1:0]    r_mode,      w_mode_nxt;
  logic          r_found,     w_found_nxt;
  logic [W-1:0]  r_x,         w_x_nxt;
  logic          r_out_valid, w_out_valid_nxt;
  logic          r_in_ready,  w_in_ready_nxt;

  logic [W-1:0]  w_p;
  logic          w_hit;

  // Low W bits of the product are exactly the mod-2^W result
  assign w_p = r_cnt[W-1:0] * r_s;

  always_comb begin
    w_hit = 1'b0;
    unique case (r_mode)
      2'b00:   w_hit = (w_p <= r_t);
      2'b01:   w_hit = (w_p <  r_t);
      2'b10:   w_hit = (w_p >= r_t);
      default: w_hit = (w_p >  r_t);
    endcase
  end

`ifdef INV_COND_EN
  logic [W-1:0] w_m;
  logic         w_cond;

  assign w_m = (-r_s) | r_s;

  always_comb begin
    w_cond = 1'b1;
    unique case (r_mode)
      2'b00:   w_cond = 1'b1;
      2'b01:   w_cond = (r_t != '0);
      2'b10:   w_cond = (r_t <= w_m);
      default: w_cond = (r_t <  w_m);
    endcase
  end
`endif

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_s_nxt     = r_s;
    w_t_nxt     = r_t;
    w_mode_nxt  = r_mode;
    w_found_nxt = r_found;
    w_x_nxt     = r_x;

    unique case (r_state)
      S_IDLE: begin
        if (bus.in_valid && r_in_ready) begin
          w_s_nxt     = bus.in_s;
          w_t_nxt     = bus.in_t;
          w_mode_nxt  = bus.in_mode;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SEARCH;
        end
      end
      S_SEARCH: begin
`ifdef INV_COND_EN
        if ((r_cnt == '0) && !w_cond) begin
          w_found_nxt = 1'b0;
          w_x_nxt     = '0;
          w_state_nxt = S_DONE;
        end else
`endif
        if (w_hit) begin
          w_found_nxt = 1'b1;
          w_x_nxt     = r_cnt[W-1:0];
          w_state_nxt = S_DONE;
        end else if (r_cnt == LAST) begin
          w_found_nxt = 1'b0;
          w_x_nxt     = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_out_valid_nxt = (w_state_nxt == S_DONE);
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_s         <= '0;
      r_t         <= '0;
      r_mode      <= 2'b00;
      r_found     <= 1'b0;
      r_x         <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_s         <= w_s_nxt;
      r_t         <= w_t_nxt;
      r_mode      <= w_mode_nxt;
      r_found     <= w_found_nxt;
      r_x         <= w_x_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_found = r_found;
  assign bus.out_x     = r_x;

endmodule

// File: tb/tb_inv_bvcmp_bvmul_search.sv
// Directed bench for inv_bvcmp_bvmul_search at W=4; expectations depend on INV_COND_EN.
module tb_inv_bvcmp_bvmul_search;

  localparam int unsigned W = 4;
  localparam int MAXLAT = 40;
`ifdef INV_COND_EN
  localparam int NOSOL_LAT = 2;
`else
  localparam int NOSOL_LAT = 17;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  inv_bvcmp_bvmul_search_if #(.W(W)) bus ();

  inv_bvcmp_bvmul_search #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept edge counts as 1; lat is the edge count after which out_valid is seen high.
  task automatic do_req(input logic [W-1:0] s, input logic [W-1:0] t,
                        input logic [1:0] m, output int lat);
    bus.in_s     = s;
    bus.in_t     = t;
    bus.in_mode  = m;
    bus.in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    bus.in_valid = 1'b0;
    bus.in_s     = ~s;
    bus.in_t     = ~t;
    bus.in_mode  = ~m;
    while (bus.out_valid !== 1'b1 && lat < MAXLAT) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic do_ack();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_found !== 1'b0) begin errors++; $display("FAIL reset_out_found got %b exp 0", bus.out_found); end
    checks++; if (bus.out_x !== 4'd0)     begin errors++; $display("FAIL reset_out_x got %0d exp 0", bus.out_x); end
  endtask

  task automatic test_ule_first();
    int lat;
    do_req(4'd3, 4'd5, 2'b00, lat);
    checks++; if (lat !== 2)              begin errors++; $display("FAIL ule_lat got %0d exp 2", lat); end
    checks++; if (bus.out_found !== 1'b1) begin errors++; $display("FAIL ule_found got %b exp 1", bus.out_found); end
    checks++; if (bus.out_x !== 4'd0)     begin errors++; $display("FAIL ule_x got %0d exp 0", bus.out_x); end
    do_ack();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ule_ack_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL ule_ack_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_uge_sweep();
    int lat;
    do_req(4'd3, 4'd7, 2'b10, lat);
    checks++; if (lat !== 5)              begin errors++; $display("FAIL uge_lat got %0d exp 5", lat); end
    checks++; if (bus.out_found !== 1'b1) begin errors++; $display("FAIL uge_found got %b exp 1", bus.out_found); end
    checks++; if (bus.out_x !== 4'd3)     begin errors++; $display("FAIL uge_x got %0d exp 3", bus.out_x); end
    do_ack();
  endtask

  task automatic test_hold_backpressure();
    int lat;
    do_req(4'd2, 4'd13, 2'b11, lat);
    checks++; if (lat !== 9)              begin errors++; $display("FAIL ugt_lat got %0d exp 9", lat); end
    bus.in_valid = 1'b1;
    bus.in_s     = 4'd1;
    bus.in_t     = 4'd0;
    bus.in_mode  = 2'b10;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc %0d got %b exp 1", i, bus.out_valid); end
      checks++; if (bus.out_found !== 1'b1) begin errors++; $display("FAIL hold_found cyc %0d got %b exp 1", i, bus.out_found); end
      checks++; if (bus.out_x !== 4'd7)     begin errors++; $display("FAIL hold_x cyc %0d got %0d exp 7", i, bus.out_x); end
      checks++; if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL hold_in_ready cyc %0d got %b exp 0", i, bus.in_ready); end
      @(posedge clk);
      #1;
    end
    do_ack();
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL hold_ack_ready got %b exp 1", bus.in_ready); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_no_new_req got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_no_solution();
    int lat;
    do_req(4'd4, 4'd13, 2'b11, lat);
    checks++; if (lat !== NOSOL_LAT)      begin errors++; $display("FAIL nosol_lat got %0d exp %0d", lat, NOSOL_LAT); end
    checks++; if (bus.out_found !== 1'b0) begin errors++; $display("FAIL nosol_found got %b exp 0", bus.out_found); end
    checks++; if (bus.out_x !== 4'd0)     begin errors++; $display("FAIL nosol_x got %0d exp 0", bus.out_x); end
    do_ack();
  endtask

  task automatic test_ult_zero();
    int lat;
    do_req(4'd3, 4'd0, 2'b01, lat);
    checks++; if (lat !== NOSOL_LAT)      begin errors++; $display("FAIL ult0_lat got %0d exp %0d", lat, NOSOL_LAT); end
    checks++; if (bus.out_found !== 1'b0) begin errors++; $display("FAIL ult0_found got %b exp 0", bus.out_found); end
    checks++; if (bus.out_x !== 4'd0)     begin errors++; $display("FAIL ult0_x got %0d exp 0", bus.out_x); end
    do_ack();
  endtask

  task automatic test_s_zero();
    int lat;
    do_req(4'd0, 4'd0, 2'b10, lat);
    checks++; if (lat !== 2)              begin errors++; $display("FAIL s0_hit_lat got %0d exp 2", lat); end
    checks++; if (bus.out_found !== 1'b1) begin errors++; $display("FAIL s0_hit_found got %b exp 1", bus.out_found); end
    do_ack();
    do_req(4'd0, 4'd5, 2'b10, lat);
    checks++; if (lat !== NOSOL_LAT)      begin errors++; $display("FAIL s0_miss_lat got %0d exp %0d", lat, NOSOL_LAT); end
    checks++; if (bus.out_found !== 1'b0) begin errors++; $display("FAIL s0_miss_found got %b exp 0", bus.out_found); end
    do_ack();
  endtask

  task automatic test_reset_mid_search();
    int lat;
    bus.in_s     = 4'd1;
    bus.in_t     = 4'd15;
    bus.in_mode  = 2'b10;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL rst_mid_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_x !== 4'd0)     begin errors++; $display("FAIL rst_mid_x got %0d exp 0", bus.out_x); end
    #2;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_abort_valid got %b exp 0", bus.out_valid); end
    do_req(4'd1, 4'd2, 2'b10, lat);
    checks++; if (lat !== 4)              begin errors++; $display("FAIL post_rst_lat got %0d exp 4", lat); end
    checks++; if (bus.out_found !== 1'b1) begin errors++; $display("FAIL post_rst_found got %b exp 1", bus.out_found); end
    checks++; if (bus.out_x !== 4'd2)     begin errors++; $display("FAIL post_rst_x got %0d exp 2", bus.out_x); end
    do_ack();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_s      = '0;
    bus.in_t      = '0;
    bus.in_mode   = 2'b00;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_ule_first();
    test_uge_sweep();
    test_hold_backpressure();
    test_no_solution();
    test_ult_zero();
    test_s_zero();
    test_reset_mid_search();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_bvcmp_bvmul_search.md
Name: inv_bvcmp_bvmul_search

Overview:
- Parametrised sequential inverse solver for bit-vector constraints of the form (x * s) CMP t.
  - Width W, mod-2^W multiply, unsigned compare.
  - CMP is selectable per request: ule, ult, uge or ugt.
- Returns the smallest x satisfying the constraint, or reports that no solution exists.
- Sits behind the Skolem-function generators as the runtime witness engine and replaces fixed-width, single-predicate combinational tables.

Parameters:
- W, 4, operand and result width in bits (2..16).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_s  in  W  multiplier operand s.
- in_t  in  W  comparison bound t.
- in_mode  in  2  predicate select: 00 ule, 01 ult, 10 uge, 11 ugt.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_found  out  1  1 = solution exists.
- out_x  out  W  smallest satisfying x; 0 when out_found = 0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n); all state clears immediately on rst_n low.
- Reset values:
  - State = IDLE.
  - in_ready = 1.
  - out_valid = 0.
  - out_found = 0.
  - out_x = 0.
  - Internal candidate counter = 0.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at cycle A: capture s, t and mode into registers, clear the candidate counter, go to SEARCH.
- SEARCH:
  - in_ready = 0.
  - Each cycle evaluates exactly one candidate x = counter, W+1-bit counter.
  - The product p = (x * s) mod 2^W, i.e. the low W bits of the product.
  - The mode predicate is evaluated on p versus t, unsigned.
  - Hit: latch out_x = x and out_found = 1, go to DONE.
  - Miss with x = 2^W-1: latch out_x = 0 and out_found = 0, go to DONE.
  - Otherwise increment the counter.
- Timing: candidate x is evaluated in cycle A+1+x.
  - On a hit, out_valid rises in cycle A+2+x.
  - With no solution, out_valid rises in cycle A+1+2^W.
- DONE:
  - out_valid = 1; out_found and out_x are held stable while out_ready = 0.
  - On out_ready = 1: out_valid drops next cycle and state returns to IDLE.
  - No new request is accepted in the same cycle as the result handshake.
  - Minimum spacing between accepts is therefore 3 cycles.
- Inputs in_s, in_t and in_mode are ignored outside the accept cycle; changing them mid-search has no effect.
- Boundary cases:
  - mode ule always hits at x = 0, giving latency 2.
  - mode ult with t = 0 never hits, so it runs the full sweep.
  - s = 0: p = 0 for all x, so the result depends only on 0 CMP t.
  - W = 16: the counter must not wrap before the terminal check; the W+1-bit counter guarantees this.
- Reset mid-SEARCH or mid-DONE aborts the request with no output pulse; the block returns to IDLE.

Optional Feature:
- Macro: INV_COND_EN.
- Defined: in the first SEARCH cycle (cycle A+1), the closed-form invertibility condition is evaluated first, with m = (-s | s) mod 2^W:
  - ule: always true.
  - ult: t != 0.
  - uge: t <=u m.
  - ugt: t <u m.
- If the condition is false, the block goes straight to DONE with out_found = 0 and out_x = 0, so out_valid rises at A+2.
- If the condition is true, the sweep proceeds exactly as without the macro, with identical cycle numbering; result and timing on solvable requests are unchanged.
- Undefined: the sweep always runs, and unsolvable requests take the full 2^W candidates.

Test Plan:
- W=4, s=3, t=5, mode ule, accept at A -> out_valid at A+2, found=1, x=0.
- W=4, s=3, t=7, mode uge -> hit at x=3 (p=9), out_valid at A+5, found=1, x=3.
- W=4, s=2, t=13, mode ugt -> x=7 (p=14), out_valid at A+9; hold out_ready=0 for 5 cycles -> out_valid, found and x are stable, in_ready=0 throughout, and a new in_valid is ignored.
- W=4, s=4, t=13, mode ugt -> no solution:
  - Macro undefined: out_valid at A+17, found=0, x=0.
  - INV_COND_EN defined: out_valid at A+2, found=0, x=0.
- W=4, s=3, t=0, mode ult -> found=0; rerun with INV_COND_EN -> found=0 at A+2.
- W=4, s=1, t=15, mode uge, assert rst_n=0 at A+6 -> out_valid=0, state IDLE and in_ready=1 immediately; after release, a new request s=1, t=2, mode uge returns found=1, x=2 at A'+4.
